// File: rtl/sync_fifo_writer.sv
// Buffers a valid/ready stream locally and re-emits it as single-cycle write
// pulses spaced at least GAP clocks apart, so a shallow synchronizer never overruns.
module sync_fifo_writer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int GAP   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   write_en,
  output logic [WIDTH-1:0]       data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [AW:0]      r_count;
  logic [GW-1:0]    r_gapCnt;
  logic [GW-1:0]    w_nextGapCnt;
  logic             r_writeEn;
  logic [WIDTH-1:0] r_data;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Ready comes from the registered count, so a pop in a full cycle cannot admit a push.
  assign in_ready = (r_count != FULL_CNT);
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_push   = in_valid && in_ready;

  assign write_en = r_writeEn;
  assign data     = r_data;
  assign count    = r_count;

  always_comb begin
    w_nextState  = r_state;
    w_nextGapCnt = r_gapCnt;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_nextGapCnt = GAP_LOAD;
          w_nextState  = (GAP > 1) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        w_nextGapCnt = r_gapCnt - GAP_ONE;
        if (r_gapCnt == GAP_ONE) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_gapCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_gapCnt <= w_nextGapCnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_writeEn <= 1'b0;
      r_data    <= '0;
    end else begin
      r_writeEn <= w_pop;
      if (w_pop) begin
        r_data  <= r_mem[r_rdPtr[AW-1:0]];
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_writer.sv
// Randomized scoreboard bench for sync_fifo_writer: two instances (GAP=4 and GAP=1)
// share stimulus and are each checked against a queue-based pacing model.
module tb_sync_fifo_writer;
  localparam int W  = 2;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int laneId, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s lane%0d actual %0d expected %0d at %0t", name, laneId, act, exp, $time);
    end
  endtask

  // Each lane: a DUT, a model that decides at every edge what must be issued,
  // and a monitor that pops expected pulses whenever the DUT raises write_en.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LG = (g == 0) ? 4 : 1;
    logic          inReady;
    logic          writeEn;
    logic [W-1:0]  dOut;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mq[$];
    exp_t          sb[$];
    exp_t          mE;
    exp_t          monE;
    bit            mAccept;
    int            modelCyc = 0;
    int            lastIssue = -1000;
    int            lastPulse = -1000;
    int            leftover = 0;
    logic [W-1:0]  expData = '0;

    sync_fifo_writer #(.WIDTH(W), .DEPTH(D), .GAP(LG)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (inReady),
      .write_en (writeEn),
      .data     (dOut),
      .count    (cnt)
    );

    // Model: the head leaves once GAP edges have passed since the last issue;
    // acceptance depends on occupancy before the edge, and new data never bypasses.
    initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        sb.delete();
        lastIssue = -1000;
        expData = '0;
      end else begin
        modelCyc++;
        mAccept = in_valid && (mq.size() < D);
        if (mq.size() > 0 && (modelCyc - lastIssue) >= LG) begin
          mE.d = mq.pop_front();
          mE.c = modelCyc;
          sb.push_back(mE);
          expData = mE.d;
          lastIssue = modelCyc;
        end
        if (mAccept) mq.push_back(in_data);
      end
    end

    initial forever begin
      @(negedge clk);
      if (!reset_n) begin
        lastPulse = -1000;
        checkOutput("rstWriteEn", g, int'(writeEn), 0);
        checkOutput("rstCount", g, int'(cnt), 0);
        checkOutput("rstData", g, int'(dOut), 0);
        checkOutput("rstReady", g, int'(inReady), 1);
      end else begin
        checkOutput("count", g, int'(cnt), mq.size());
        checkOutput("inReady", g, int'(inReady), (mq.size() < D) ? 1 : 0);
        checkOutput("dataHold", g, int'(dOut), int'(expData));
        if (writeEn) begin
          if (sb.size() == 0) begin
            checkOutput("unexpectedPulse", g, 1, 0);
          end else begin
            monE = sb.pop_front();
            checkOutput("pulseData", g, int'(dOut), int'(monE.d));
            checkOutput("pulseCycle", g, modelCyc, monE.c);
          end
          checkOutput("spacingOk", g, ((modelCyc - lastPulse) >= LG) ? 1 : 0, 1);
          lastPulse = modelCyc;
        end else if (sb.size() > 0 && sb[0].c <= modelCyc) begin
          monE = sb.pop_front();
          checkOutput("missedPulse", g, 0, 1);
        end
      end
      leftover = sb.size() + mq.size();
    end
  end

  task automatic applyStimulus(input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
  endtask

  // Holds the value until the GAP=4 lane has room to take it at the next edge.
  task automatic pushHold(input logic [W-1:0] d);
    int budget;
    applyStimulus(1'b1, d);
    budget = 100;
    while (!lane[0].inReady && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput("readyTimeout", 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) applyStimulus(1'b1, 2'b11);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    in_valid = 1'b0;

    applyStimulus(1'b1, 2'b10);
    repeat (10) applyStimulus(1'b0, 2'b00);

    for (int i = 0; i < 10; i++) pushHold(W'(i % 4));
    for (int i = 0; i < 12; i++) pushHold(W'($urandom));
    repeat (6) applyStimulus(1'b0, 2'b00);

    for (int i = 0; i < 9; i++) pushHold(W'($urandom));
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("asyncWriteEn", 0, int'(lane[0].writeEn), 0);
    checkOutput("asyncCount", 0, int'(lane[0].cnt), 0);
    checkOutput("asyncWriteEn", 1, int'(lane[1].writeEn), 0);
    checkOutput("asyncCount", 1, int'(lane[1].cnt), 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(1'b1, 2'b01);
    repeat (10) applyStimulus(1'b0, 2'b00);

    repeat (3 * D * 8) applyStimulus($urandom_range(0, 99) < 55, W'($urandom));
    repeat (4 * D + 20) applyStimulus(1'b0, 2'b00);

    @(negedge clk);
    @(negedge clk);
    checkOutput("drained", 0, lane[0].leftover, 0);
    checkOutput("drained", 1, lane[1].leftover, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
